// File: rtl/trap_ctrl.sv
// Trap/interrupt sequencer: an IDLE capture goes through DRAIN, then a one-cycle COMMIT of the CSR strobes, then a redirect to fetch.
// Capture cycle T; with lsu_idle high COMMIT is at T+2 and redirect_valid at T+3. redirect_valid/redirect_pc hold until redirect_ready.
module trap_ctrl #(
  parameter int VEC_STRIDE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_valid,
  input  logic        exc_valid,
  input  logic [4:0]  exc_cause,
  input  logic        mret_valid,
  input  logic        extern_intr,
  input  logic        timer_intr,
  input  logic        software_intr,
  input  logic        mstatus_mie,
  input  logic [31:0] mie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic [1:0]  privilege_mode,
  input  logic        lsu_idle,
  input  logic        redirect_ready,
  output logic        wb_kill,
  output logic        flush,
  output logic        wb_hold,
  output logic        fetch_halt,
  output logic        trap_busy,
  output logic        mcause_update,
  output logic        mepc_updata,
  output logic        is_mret,
  output logic [5:0]  mcause,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
  typedef enum logic [1:0] {K_EXC, K_INT, K_MRET} kind_t;

  localparam logic [31:0] STRIDE = 32'(VEC_STRIDE);

  state_t      state, state_nxt;
  kind_t       kind, evt_kind;
  logic        int_en, pend_e, pend_s, pend_t, int_take, evt;
  logic [5:0]  evt_cause;
  logic [31:0] base, target;
  logic        unused_mie;

  assign unused_mie = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0]};

  always_comb begin
    int_en    = mstatus_mie | (privilege_mode == 2'b00);
    pend_e    = extern_intr & mie[11];
    pend_s    = software_intr & mie[3];
    pend_t    = timer_intr & mie[7];
    int_take  = int_en & (pend_e | pend_s | pend_t);
    evt       = wb_valid & (exc_valid | int_take | mret_valid);
    // An mret keeps the old mcause, so the default re-latches the current value.
    evt_kind  = K_MRET;
    evt_cause = mcause;
    if (exc_valid) begin
      evt_kind  = K_EXC;
      evt_cause = {1'b0, exc_cause};
    end else if (int_take) begin
      evt_kind  = K_INT;
      if (pend_e)      evt_cause = 6'h2B;
      else if (pend_s) evt_cause = 6'h23;
      else             evt_cause = 6'h27;
    end
  end

  always_comb begin
    base   = {mtvec[31:2], 2'b00};
    target = base;
    if (kind == K_MRET)
      target = mepc;
    else if (kind == K_INT && mtvec[1:0] == 2'b01)
      target = base + STRIDE * {27'b0, mcause[4:0]};
  end

  always_comb begin
    state_nxt      = state;
    wb_kill        = 1'b0;
    flush          = 1'b0;
    wb_hold        = 1'b0;
    fetch_halt     = 1'b0;
    mcause_update  = 1'b0;
    mepc_updata    = 1'b0;
    is_mret        = 1'b0;
    redirect_valid = 1'b0;
    trap_busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (evt) begin
          wb_kill   = 1'b1;
          flush     = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        wb_hold    = 1'b1;
        fetch_halt = 1'b1;
        if (lsu_idle) state_nxt = COMMIT;
      end
      COMMIT: begin
        wb_hold    = 1'b1;
        fetch_halt = 1'b1;
        if (kind == K_MRET) begin
          is_mret = 1'b1;
        end else begin
          mcause_update = 1'b1;
          mepc_updata   = 1'b1;
        end
        state_nxt = REDIRECT;
      end
      REDIRECT: begin
        fetch_halt     = 1'b1;
        redirect_valid = 1'b1;
        if (redirect_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      kind        <= K_EXC;
      mcause      <= 6'h0;
      redirect_pc <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && evt) begin
        kind   <= evt_kind;
        mcause <= evt_cause;
      end
      if (state == COMMIT) redirect_pc <= target;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a timeline model checked every cycle, plus literal checks per scenario.
module tb_trap_ctrl;
  localparam int VS = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_valid, exc_valid, mret_valid;
  logic [4:0]  exc_cause;
  logic        extern_intr, timer_intr, software_intr, mstatus_mie;
  logic [31:0] mie, mtvec, mepc;
  logic [1:0]  privilege_mode;
  logic        lsu_idle, redirect_ready;
  logic        wb_kill, flush, wb_hold, fetch_halt, trap_busy;
  logic        mcause_update, mepc_updata, is_mret, redirect_valid;
  logic [5:0]  mcause;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  trap_ctrl #(.VEC_STRIDE(VS)) dut (
    .clk(clk), .reset_n(reset_n), .wb_valid(wb_valid), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .mret_valid(mret_valid), .extern_intr(extern_intr),
    .timer_intr(timer_intr), .software_intr(software_intr), .mstatus_mie(mstatus_mie),
    .mie(mie), .mtvec(mtvec), .mepc(mepc), .privilege_mode(privilege_mode),
    .lsu_idle(lsu_idle), .redirect_ready(redirect_ready), .wb_kill(wb_kill),
    .flush(flush), .wb_hold(wb_hold), .fetch_halt(fetch_halt), .trap_busy(trap_busy),
    .mcause_update(mcause_update), .mepc_updata(mepc_updata), .is_mret(is_mret),
    .mcause(mcause), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Timeline model: a trap is a record (kind, cause) plus the cycle numbers of its phases.
  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_commit = -1;
  int          m_kind = 0;          // 0 exception, 1 interrupt, 2 mret
  logic [5:0]  m_mcause = 6'h0;
  logic [31:0] m_pc = 32'h0;

  always @(negedge clk) begin
    logic        e_kill, e_hold, e_halt, e_busy, e_csr, e_mret, e_rv, ie, pe, ps, pt, nb;
    int          ncommit, nk;
    logic [5:0]  nm;
    logic [31:0] np;
    cyc++;
    e_kill = 0; e_hold = 0; e_halt = 0; e_csr = 0; e_mret = 0; e_rv = 0;
    nb = m_busy; ncommit = m_commit; nk = m_kind; nm = m_mcause; np = m_pc;
    e_busy = m_busy;
    if (!reset_n) begin
      m_mcause = 6'h0; m_pc = 32'h0; nm = 6'h0; np = 32'h0; nb = 0; e_busy = 0;
    end else if (!m_busy) begin
      ie = mstatus_mie || (privilege_mode == 2'b00);
      pe = ie && extern_intr && mie[11];
      ps = ie && software_intr && mie[3];
      pt = ie && timer_intr && mie[7];
      if (wb_valid && (exc_valid || pe || ps || pt || mret_valid)) begin
        e_kill = 1; nb = 1; ncommit = -1;
        if (exc_valid) begin nk = 0; nm = {1'b0, exc_cause}; end
        else if (pe) begin nk = 1; nm = 6'd43; end
        else if (ps) begin nk = 1; nm = 6'd35; end
        else if (pt) begin nk = 1; nm = 6'd39; end
        else nk = 2;
      end
    end else if (m_commit < 0) begin
      e_hold = 1; e_halt = 1;
      if (lsu_idle) ncommit = cyc + 1;
    end else if (cyc == m_commit) begin
      e_hold = 1; e_halt = 1;
      if (m_kind == 2) begin
        e_mret = 1; np = mepc;
      end else begin
        e_csr = 1;
        np = mtvec & 32'hFFFF_FFFC;
        if (m_kind == 1 && mtvec[1:0] == 2'b01) np = np + VS * m_mcause[4:0];
      end
    end else begin
      e_halt = 1; e_rv = 1;
      if (redirect_ready) nb = 0;
    end
    chk("wb_kill", 32'(wb_kill), 32'(e_kill));
    chk("flush", 32'(flush), 32'(e_kill));
    chk("wb_hold", 32'(wb_hold), 32'(e_hold));
    chk("fetch_halt", 32'(fetch_halt), 32'(e_halt));
    chk("trap_busy", 32'(trap_busy), 32'(e_busy));
    chk("mcause_update", 32'(mcause_update), 32'(e_csr));
    chk("mepc_updata", 32'(mepc_updata), 32'(e_csr));
    chk("is_mret", 32'(is_mret), 32'(e_mret));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    chk("mcause", 32'(mcause), 32'(m_mcause));
    chk("redirect_pc", redirect_pc, m_pc);
    m_busy = nb; m_commit = ncommit; m_kind = nk; m_mcause = nm; m_pc = np;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_evt();
    wb_valid = 0; exc_valid = 0; mret_valid = 0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (trap_busy && k < 60) begin
      step();
      k++;
    end
    chk({nm, "_done"}, 32'(trap_busy), 32'd0);
  endtask

  // Event inputs are already applied for cycle T; lsu_idle and redirect_ready high.
  task automatic run_trap(input string nm, input logic [5:0] exp_mc, input logic [31:0] exp_pc);
    @(negedge clk);
    chk({nm, "_kill"}, 32'(wb_kill), 32'd1);
    step();
    clear_evt();
    step();
    @(negedge clk);
    chk({nm, "_mcu"}, 32'(mcause_update), 32'd1);
    chk({nm, "_mepu"}, 32'(mepc_updata), 32'd1);
    chk({nm, "_nomret"}, 32'(is_mret), 32'd0);
    chk({nm, "_mcause"}, 32'(mcause), 32'(exp_mc));
    step();
    @(negedge clk);
    chk({nm, "_rv"}, 32'(redirect_valid), 32'd1);
    chk({nm, "_pc"}, redirect_pc, exp_pc);
    wait_idle(nm);
  endtask

  initial begin
    int pulses, drains;
    logic [31:0] seen_pc;
    reset_n = 0; clear_evt(); exc_cause = 0;
    extern_intr = 0; timer_intr = 0; software_intr = 0; mstatus_mie = 0;
    mie = 0; mtvec = 0; mepc = 0; privilege_mode = 2'b11;
    lsu_idle = 1; redirect_ready = 1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_mcause", 32'(mcause), 32'h0);
    chk("rst_pc", redirect_pc, 32'h0);
    chk("rst_halt", 32'(fetch_halt), 32'h0);
    step();
    reset_n = 1;
    step();

    // Illegal instruction, vectored mtvec but exceptions go to base.
    wb_valid = 1; exc_valid = 1; exc_cause = 5'd2; mtvec = 32'h8000_0101;
    run_trap("exc", 6'h02, 32'h8000_0100);

    // Vectored timer interrupt.
    step();
    mstatus_mie = 1; mie = 32'h80; timer_intr = 1; mtvec = 32'h8000_0001; wb_valid = 1;
    run_trap("tmr", 6'h27, 32'h8000_001C);
    timer_intr = 0;

    // All sources pending with an mret in WB: external wins, the mret is killed.
    step();
    mie = 32'h888; extern_intr = 1; software_intr = 1; timer_intr = 1;
    wb_valid = 1; mret_valid = 1;
    run_trap("all", 6'h2B, 32'h8000_002C);
    extern_intr = 0; software_intr = 0; timer_intr = 0;

    // mret with a three-cycle drain.
    step();
    mepc = 32'h0000_1234; wb_valid = 1; mret_valid = 1; lsu_idle = 0;
    @(negedge clk);
    chk("mret_kill", 32'(wb_kill), 32'd1);
    pulses = 0; drains = 0; seen_pc = 32'h0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 0) clear_evt();
      if (k == 2) lsu_idle = 1;
      @(negedge clk);
      if (is_mret) pulses++;
      if (wb_hold && !is_mret) drains++;
      if (redirect_valid) seen_pc = redirect_pc;
    end
    chk("mret_pulses", 32'(pulses), 32'd1);
    chk("mret_drain", 32'(drains), 32'd3);
    chk("mret_pc", seen_pc, 32'h0000_1234);
    chk("mret_mcause", 32'(mcause), 32'h2B);
    chk("mret_idle", 32'(trap_busy), 32'd0);

    // Masked in M-mode, taken in U-mode.
    step();
    mstatus_mie = 0; privilege_mode = 2'b11; mie = 32'h80; timer_intr = 1;
    mtvec = 32'h0000_0200; wb_valid = 1;
    @(negedge clk);
    chk("mask_kill", 32'(wb_kill), 32'd0);
    step();
    clear_evt();
    @(negedge clk);
    chk("mask_idle", 32'(trap_busy), 32'd0);
    step();
    privilege_mode = 2'b00; wb_valid = 1;
    run_trap("umode", 6'h27, 32'h0000_0200);
    timer_intr = 0; privilege_mode = 2'b11;

    // Exception plus mret, mtvec mode 2 treated as direct, redirect backpressure.
    step();
    mtvec = 32'h0000_0402; mepc = 32'h0000_7770; redirect_ready = 0;
    wb_valid = 1; exc_valid = 1; exc_cause = 5'd5; mret_valid = 1;
    @(negedge clk);
    chk("bp_kill", 32'(wb_kill), 32'd1);
    step();
    clear_evt();
    step();
    @(negedge clk);
    chk("bp_mcause", 32'(mcause), 32'h05);
    chk("bp_nomret", 32'(is_mret), 32'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rv", 32'(redirect_valid), 32'd1);
      chk("bp_pc", redirect_pc, 32'h0000_0400);
      step();
    end
    redirect_ready = 1;
    wait_idle("bp");

    // Reset while draining.
    step();
    lsu_idle = 0; wb_valid = 1; exc_valid = 1; exc_cause = 5'd1;
    step();
    clear_evt();
    @(negedge clk);
    chk("rd_busy", 32'(trap_busy), 32'd1);
    step();
    reset_n = 0;
    @(negedge clk);
    chk("rd_busy0", 32'(trap_busy), 32'd0);
    chk("rd_hold0", 32'(wb_hold), 32'd0);
    chk("rd_halt0", 32'(fetch_halt), 32'd0);
    chk("rd_mcause0", 32'(mcause), 32'h0);
    chk("rd_pc0", redirect_pc, 32'h0);
    step();
    reset_n = 1; lsu_idle = 1;
    repeat (5) step();
    @(negedge clk);
    chk("rd_quiet", 32'(trap_busy), 32'd0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
